// File: rtl/fir_axis_out_fifo_pkg.sv
// Shared types and default sizes for the FIR output stream path.
package fir_axis_out_fifo_pkg;

    localparam int FIR_DATA_WIDTH     = 32;
    localparam int FIR_OUT_FIFO_DEPTH = 8;

    typedef struct packed {
        logic               last;
        logic signed [31:0] data;
    } axis_beat_t;

endpackage

// File: rtl/fir_axis_out_fifo.sv
// First-word-fall-through AXI-Stream FIFO behind the FIR result port.
// Carries tlast per beat, reports occupancy and end-of-frame on tlast pop.
module fir_axis_out_fifo
    import fir_axis_out_fifo_pkg::*;
#(
    parameter int pDATA_WIDTH = FIR_DATA_WIDTH,
    parameter int pDEPTH      = FIR_OUT_FIFO_DEPTH,
    parameter int pLVL_WIDTH  = $clog2(pDEPTH) + 1
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [pLVL_WIDTH-1:0]  level,
    output logic                   frame_done
);

    localparam int PTR_W = $clog2(pDEPTH);
    localparam logic [pLVL_WIDTH-1:0] LVL_FULL = pLVL_WIDTH'(pDEPTH);

    logic [pDATA_WIDTH:0]  mem_q [pDEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [pLVL_WIDTH-1:0] level_q, level_d;
    logic                  s_tready_q, s_tready_d;
    logic                  frame_done_q, frame_done_d;
    logic                  push, pop;

    assign m_tvalid   = (level_q != '0);
    assign push       = s_tvalid & s_tready_q;
    assign pop        = m_tvalid & m_tready;
    assign {m_tlast, m_tdata} = mem_q[rd_ptr_q];
    assign s_tready   = s_tready_q;
    assign level      = level_q;
    assign frame_done = frame_done_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + pLVL_WIDTH'(1);
        end else if (pop && !push) begin
            level_d = level_q - pLVL_WIDTH'(1);
        end
        // Ready looks only at the next occupancy, so a pop never frees a slot in the same cycle.
        s_tready_d   = (level_d < LVL_FULL);
        frame_done_d = pop & m_tlast;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            s_tready_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            s_tready_q   <= s_tready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Array is cleared on reset so the head output is never X while idle.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < pDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
        end
    end

endmodule

// File: tb/tb_fir_axis_out_fifo.sv
// Bench for fir_axis_out_fifo: queue-based reference model, scenario tasks.
module tb_fir_axis_out_fifo;
    import fir_axis_out_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready = 1'b0;
    logic [3:0]  level;
    logic        frame_done;

    fir_axis_out_fifo dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .level      (level),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue of beats plus the two registered flags.
    axis_beat_t mq[$];
    bit         mdl_rdy = 1'b0;
    bit         mdl_fd  = 1'b0;

    // Observed (DUT) and expected (model) values for the current cycle.
    logic        o_rdy, o_val, o_last, o_fd;
    logic [31:0] o_dat;
    logic [3:0]  o_lvl;
    logic        e_rdy, e_val, e_last, e_fd;
    logic [31:0] e_dat;
    logic [3:0]  e_lvl;
    bit          did_push, did_pop;

    task automatic model_reset();
        mq.delete();
        mdl_rdy = 1'b0;
        mdl_fd  = 1'b0;
    endtask

    // Drive one cycle from the falling edge, capture DUT/model, advance the model at the rising edge.
    task automatic cyc(input bit v, input logic [31:0] d, input bit l, input bit r);
        axis_beat_t b;
        s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
        #1;
        o_rdy = s_tready; o_val = m_tvalid; o_dat = m_tdata;
        o_last = m_tlast; o_lvl = level; o_fd = frame_done;
        e_rdy = mdl_rdy;
        e_val = (mq.size() != 0);
        e_dat = e_val ? mq[0].data : 32'h0;
        e_last = e_val ? mq[0].last : 1'b0;
        e_lvl = 4'(mq.size());
        e_fd  = mdl_fd;
        did_push = v && mdl_rdy;
        did_pop  = e_val && r;
        @(posedge clk);
        mdl_fd = did_pop && mq[0].last;
        if (did_pop) b = mq.pop_front();
        if (did_push) begin
            b.last = l;
            b.data = d;
            mq.push_back(b);
        end
        mdl_rdy = (mq.size() < 8);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0; m_tready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({s_tready, m_tvalid, m_tdata, m_tlast, level, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b val=%b dat=%h last=%b lvl=%0d fd=%b want all 0",
                     s_tready, m_tvalid, m_tdata, m_tlast, level, frame_done);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (s_tready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_before_edge: got %b want 0", s_tready);
        end
        @(posedge clk); #1;
        mdl_rdy = 1'b1;
        n_cmp++;
        if (s_tready !== 1'b1 || level !== 4'd0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b lvl=%0d want rdy=1 lvl=0", s_tready, level);
        end
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        logic [31:0] vals [8];
        vals = '{32'd0, -32'sd10, -32'sd19, 32'd4, 32'd60, 32'd123, 32'd186, 32'd242};
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, vals[i], i == 7, 1'b0);
            n_cmp++;
            if (o_lvl !== 4'(i) || o_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL fill_level: got lvl=%0d rdy=%b want lvl=%0d rdy=1", o_lvl, o_rdy, i);
            end
        end
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        n_cmp++;
        if (o_lvl !== 4'd8 || o_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL full_state: got lvl=%0d rdy=%b want lvl=8 rdy=0", o_lvl, o_rdy);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
            n_cmp++;
            if (o_val !== 1'b1 || o_dat !== vals[i] || o_lvl !== 4'(8 - i) || o_last !== (i == 7)) begin
                n_err++;
                $display("FAIL drain_beat%0d: got val=%b dat=%h last=%b lvl=%0d want val=1 dat=%h last=%b lvl=%0d",
                         i, o_val, o_dat, o_last, o_lvl, vals[i], (i == 7), 8 - i);
            end
            if (i == 0) begin
                n_cmp++;
                if (o_rdy !== 1'b0) begin
                    n_err++;
                    $display("FAIL ninth_push_rejected: got rdy=%b want 0", o_rdy);
                end
            end
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        n_cmp++;
        if (o_val !== 1'b0 || o_lvl !== 4'd0 || o_rdy !== 1'b1 || o_fd !== 1'b1) begin
            n_err++;
            $display("FAIL drain_end: got val=%b lvl=%0d rdy=%b fd=%b want val=0 lvl=0 rdy=1 fd=1",
                     o_val, o_lvl, o_rdy, o_fd);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] stream [600];
        int fd_cnt = 0;
        int fd_at  = -1;
        int errs   = 0;
        for (int i = 0; i < 600; i++) stream[i] = $urandom;
        for (int c = 0; c < 603; c++) begin
            if (c < 600) cyc(1'b1, stream[c], c == 599, 1'b1);
            else         cyc(1'b0, 32'h0, 1'b0, 1'b1);
            if (o_fd === 1'b1) begin fd_cnt++; fd_at = c; end
            if (c >= 1 && c <= 600) begin
                n_cmp++;
                if (o_val !== 1'b1 || o_dat !== stream[c-1] || o_last !== (c == 600) || o_lvl !== 4'd1) begin
                    n_err++; errs++;
                    if (errs < 5)
                        $display("FAIL stream_beat%0d: got val=%b dat=%h last=%b lvl=%0d want val=1 dat=%h last=%b lvl=1",
                                 c - 1, o_val, o_dat, o_last, o_lvl, stream[c-1], (c == 600));
                end
            end
        end
        n_cmp++;
        if (fd_cnt != 1 || fd_at != 601) begin
            n_err++;
            $display("FAIL stream_frame_done: got count=%0d cycle=%0d want count=1 cycle=601", fd_cnt, fd_at);
        end
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, $urandom, 1'b0, 1'b1);
            n_cmp++;
            if (o_lvl !== 4'd3 || o_val !== 1'b1 || o_dat !== e_dat || o_rdy !== 1'b1) begin
                n_err++; errs++;
                if (errs < 5)
                    $display("FAIL b2b_level3_cyc%0d: got lvl=%0d dat=%h rdy=%b want lvl=3 dat=%h rdy=1",
                             i, o_lvl, o_dat, o_rdy, e_dat);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
            n_cmp++;
            if (o_dat !== e_dat || o_lvl !== e_lvl) begin
                n_err++;
                $display("FAIL b2b_drain%0d: got dat=%h lvl=%0d want dat=%h lvl=%0d", i, o_dat, o_lvl, e_dat, e_lvl);
            end
        end
    endtask

    task automatic test_random_backpressure();
        int pushes = 0, pops = 0, cycles = 0, errs = 0;
        logic        p_val = 1'b0, p_rdy = 1'b1, p_last = 1'b0;
        logic [31:0] p_dat = '0;
        while (pushes < 1000 && cycles < 8000) begin
            cyc($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
            cycles++;
            n_cmp++;
            if (o_rdy !== e_rdy || o_val !== e_val || o_lvl !== 4'(pushes - pops) || o_fd !== e_fd ||
                (e_val && (o_dat !== e_dat || o_last !== e_last))) begin
                n_err++; errs++;
                if (errs < 5)
                    $display("FAIL rand_cyc%0d: got rdy=%b val=%b dat=%h last=%b lvl=%0d fd=%b want rdy=%b val=%b dat=%h last=%b lvl=%0d fd=%b",
                             cycles, o_rdy, o_val, o_dat, o_last, o_lvl, o_fd,
                             e_rdy, e_val, e_dat, e_last, 4'(pushes - pops), e_fd);
            end
            if (p_val && !p_rdy) begin
                n_cmp++;
                if (o_val !== 1'b1 || o_dat !== p_dat || o_last !== p_last) begin
                    n_err++; errs++;
                    if (errs < 5)
                        $display("FAIL rand_stall_stable: got val=%b dat=%h last=%b want val=1 dat=%h last=%b",
                                 o_val, o_dat, o_last, p_dat, p_last);
                end
            end
            p_val = o_val; p_dat = o_dat; p_last = o_last; p_rdy = m_tready;
            if (did_push) pushes++;
            if (did_pop) pops++;
        end
        n_cmp++;
        if (pushes < 1000) begin
            n_err++;
            $display("FAIL rand_timeout: got pushes=%0d want 1000", pushes);
        end
        while (mq.size() != 0 && cycles < 9000) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
            cycles++;
            n_cmp++;
            if (o_dat !== e_dat || o_last !== e_last || o_lvl !== e_lvl) begin
                n_err++;
                $display("FAIL rand_drain: got dat=%h last=%b lvl=%0d want dat=%h last=%b lvl=%0d",
                         o_dat, o_last, o_lvl, e_dat, e_last, e_lvl);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + i, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (level !== 4'd5) begin
            n_err++;
            $display("FAIL midrst_pre_level: got %0d want 5", level);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_tvalid !== 1'b0 || level !== 4'd0 || s_tready !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_immediate: got val=%b lvl=%0d rdy=%b fd=%b want all 0",
                     m_tvalid, level, s_tready, frame_done);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        mdl_rdy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
            n_cmp++;
            if (o_val !== 1'b0 || o_lvl !== 4'd0 || o_fd !== 1'b0 || o_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_no_stale%0d: got val=%b lvl=%0d fd=%b rdy=%b want val=0 lvl=0 fd=0 rdy=1",
                         i, o_val, o_lvl, o_fd, o_rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_back_to_back();
        test_random_backpressure();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
